// File: rtl/cmp_pkg.sv
// Shared definitions for the cmp consumer path: condition codes,
// NZCV bit positions and the query FSM state type.
package cmp_pkg;

    localparam logic [3:0] COND_EQ  = 4'd0;
    localparam logic [3:0] COND_NE  = 4'd1;
    localparam logic [3:0] COND_LT  = 4'd2;
    localparam logic [3:0] COND_GE  = 4'd3;
    localparam logic [3:0] COND_GT  = 4'd4;
    localparam logic [3:0] COND_LE  = 4'd5;
    localparam logic [3:0] COND_LTU = 4'd6;
    localparam logic [3:0] COND_GEU = 4'd7;
    localparam logic [3:0] COND_GTU = 4'd8;
    localparam logic [3:0] COND_LEU = 4'd9;
    localparam logic [3:0] COND_MI  = 4'd10;
    localparam logic [3:0] COND_PL  = 4'd11;
    localparam logic [3:0] COND_VS  = 4'd12;
    localparam logic [3:0] COND_VC  = 4'd13;
    localparam logic [3:0] COND_AL  = 4'd14;
    localparam logic [3:0] COND_NV  = 4'd15;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/cond_decode.sv
// Combinational NZCV + condition-code to taken mapping.
module cond_decode
    import cmp_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Evaluate the requested condition against the supplied flags
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_EQ:  taken = z;
            COND_NE:  taken = !z;
            COND_LT:  taken = n ^ v;
            COND_GE:  taken = !(n ^ v);
            COND_GT:  taken = !z && !(n ^ v);
            COND_LE:  taken = z || (n ^ v);
            COND_LTU: taken = !c;
            COND_GEU: taken = c;
            COND_GTU: taken = c && !z;
            COND_LEU: taken = !c || z;
            COND_MI:  taken = n;
            COND_PL:  taken = !n;
            COND_VS:  taken = v;
            COND_VC:  taken = !v;
            COND_AL:  taken = 1'b1;
            COND_NV:  taken = 1'b0;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_cond_unit.sv
// Consumer of the cmp interface: holds architectural NZCV, answers
// branch-condition queries over a valid/ready handshake, and counts
// taken responses for the perf counters.
module cmp_cond_unit
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              FlagWe,
    input  logic [DATA_W-1:0] CmpOut,
    input  logic              CmpCarry,
    input  logic              CmpOverflow,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [3:0]        ReqCond,
    output logic              RspValid,
    input  logic              RspReady,
    output logic              RspTaken,
    output logic [3:0]        Flags,
    output logic              FlagsValid,
    output logic [CNT_W-1:0]  TakenCnt
);

    state_t            state;
    logic [3:0]        flags_r;
    logic              flags_valid_r;
    logic              rsp_taken_r;
    logic [CNT_W-1:0]  taken_cnt_r;

    logic [3:0]        new_flags;
    logic [3:0]        eval_flags;
    logic              have_flags;
    logic              accept;
    logic              dec_taken;

    // Flags as they would be captured from the current cmp result
    always_comb begin
        new_flags         = '0;
        new_flags[FLAG_N] = CmpOut[DATA_W-1];
        new_flags[FLAG_Z] = (CmpOut == '0);
        new_flags[FLAG_C] = CmpCarry;
        new_flags[FLAG_V] = CmpOverflow;
    end

    // A same-cycle flag write is forwarded so the query sees the fresh result
    always_comb begin
        eval_flags = FlagWe ? new_flags : flags_r;
        have_flags = flags_valid_r | FlagWe;
        if (state == ST_IDLE) begin
            ReqReady = have_flags;
        end else begin
            ReqReady = RspReady & have_flags;
        end
        accept = ReqValid & ReqReady;
    end

    cond_decode u_cond_decode (
        .flags (eval_flags),
        .cond  (ReqCond),
        .taken (dec_taken)
    );

    // Flag register, query FSM and saturating taken counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= ST_IDLE;
            flags_r       <= '0;
            flags_valid_r <= 1'b0;
            rsp_taken_r   <= 1'b0;
            taken_cnt_r   <= '0;
        end else begin
            if (FlagWe) begin
                flags_r       <= new_flags;
                flags_valid_r <= 1'b1;
            end

            if ((state == ST_RESP) && RspReady && rsp_taken_r && (taken_cnt_r != '1)) begin
                taken_cnt_r <= taken_cnt_r + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_RESP;
                        rsp_taken_r <= dec_taken;
                    end
                end
                ST_RESP: begin
                    if (RspReady) begin
                        if (accept) begin
                            rsp_taken_r <= dec_taken;
                        end else begin
                            state       <= ST_IDLE;
                            rsp_taken_r <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign RspValid   = (state == ST_RESP);
    assign RspTaken   = rsp_taken_r;
    assign Flags      = flags_r;
    assign FlagsValid = flags_valid_r;
    assign TakenCnt   = taken_cnt_r;

endmodule

// File: tb/tb_cmp_cond_unit.sv
// Randomized and directed checks of cmp_cond_unit against an operand-level
// model: expected results come from comparing the cmp operands directly.
module tb_cmp_cond_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int          CNT_MAX = 3;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              FlagWe = 1'b0;
    logic [DATA_W-1:0] CmpOut = '0;
    logic              CmpCarry = 1'b0;
    logic              CmpOverflow = 1'b0;
    logic              ReqValid = 1'b0;
    logic              ReqReady;
    logic [3:0]        ReqCond = '0;
    logic              RspValid;
    logic              RspReady = 1'b0;
    logic              RspTaken;
    logic [3:0]        Flags;
    logic              FlagsValid;
    logic [CNT_W-1:0]  TakenCnt;

    cmp_cond_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .FlagWe      (FlagWe),
        .CmpOut      (CmpOut),
        .CmpCarry    (CmpCarry),
        .CmpOverflow (CmpOverflow),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqCond     (ReqCond),
        .RspValid    (RspValid),
        .RspReady    (RspReady),
        .RspTaken    (RspTaken),
        .Flags       (Flags),
        .FlagsValid  (FlagsValid),
        .TakenCnt    (TakenCnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition outcome from plain signed/unsigned comparison of a and b
    function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cond);
        logic slt, ult, eq, n, v;
        logic [31:0] d;
        d   = a - b;
        slt = $signed(a) < $signed(b);
        ult = a < b;
        eq  = (a == b);
        n   = d[31];
        v   = slt ^ n;
        case (cond)
            4'd0:  return eq;
            4'd1:  return !eq;
            4'd2:  return slt;
            4'd3:  return !slt;
            4'd4:  return !slt && !eq;
            4'd5:  return slt || eq;
            4'd6:  return ult;
            4'd7:  return !ult;
            4'd8:  return !ult && !eq;
            4'd9:  return ult || eq;
            4'd10: return n;
            4'd11: return !n;
            4'd12: return v;
            4'd13: return !v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic slt;
        d   = a - b;
        slt = $signed(a) < $signed(b);
        return {d[31], (a == b), !(a < b), slt ^ d[31]};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic bump(input logic taken);
        if (taken && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic set_cmp(input logic [31:0] a, input logic [31:0] b);
        logic [3:0] f;
        f           = ref_flags(a, b);
        CmpOut      = a - b;
        CmpCarry    = f[1];
        CmpOverflow = f[0];
    endtask

    task automatic write_flags(input logic [31:0] a, input logic [31:0] b);
        set_cmp(a, b);
        FlagWe = 1'b1;
        step();
        FlagWe = 1'b0;
        check("flags", 32'(Flags), 32'(ref_flags(a, b)));
        check("flags_valid", 32'(FlagsValid), 32'd1);
    endtask

    // Issue one query, hold no backpressure, complete the response
    task automatic query(input logic [3:0] cond, input logic exp);
        ReqValid = 1'b1;
        ReqCond  = cond;
        RspReady = 1'b0;
        #1;
        check("req_ready", 32'(ReqReady), 32'd1);
        step();
        ReqValid = 1'b0;
        check("rsp_valid", 32'(RspValid), 32'd1);
        check("rsp_taken", 32'(RspTaken), 32'(exp));
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        bump(exp);
        check("rsp_done", 32'(RspValid), 32'd0);
        check("taken_cnt", 32'(TakenCnt), 32'(exp_cnt));
    endtask

    // Query accepted in the same cycle as the flag write
    task automatic query_fwd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cond);
        set_cmp(a, b);
        FlagWe   = 1'b1;
        ReqValid = 1'b1;
        ReqCond  = cond;
        #1;
        check("fwd_ready", 32'(ReqReady), 32'd1);
        step();
        FlagWe   = 1'b0;
        ReqValid = 1'b0;
        check("fwd_taken", 32'(RspTaken), 32'(ref_taken(a, b, cond)));
        check("fwd_flags", 32'(Flags), 32'(ref_flags(a, b)));
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        bump(ref_taken(a, b, cond));
        check("fwd_cnt", 32'(TakenCnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic [3:0]  c;

        // Reset
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        exp_cnt = 0;
        check("rst_flags", 32'(Flags), 32'd0);
        check("rst_fvalid", 32'(FlagsValid), 32'd0);
        check("rst_rspvalid", 32'(RspValid), 32'd0);
        check("rst_cnt", 32'(TakenCnt), 32'd0);

        // Query stalls until the first flag write
        ReqValid = 1'b1;
        ReqCond  = 4'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_ready", 32'(ReqReady), 32'd0);
            check("stall_rsp", 32'(RspValid), 32'd0);
            step();
        end
        set_cmp(32'd10, 32'd15);
        FlagWe = 1'b1;
        #1;
        check("first_we_ready", 32'(ReqReady), 32'd1);
        step();
        FlagWe   = 1'b0;
        ReqValid = 1'b0;
        check("basic_flags", 32'(Flags), 32'b1000);
        check("basic_lt_valid", 32'(RspValid), 32'd1);
        check("basic_lt", 32'(RspTaken), 32'd1);
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        bump(1'b1);
        check("basic_lt_done", 32'(RspValid), 32'd0);
        query(4'd6, 1'b1);
        query(4'd3, 1'b0);
        query(4'd7, 1'b0);

        // Mixed-sign operands: 10 - (-15)
        write_flags(32'd10, 32'hFFFF_FFF1);
        query(4'd4, 1'b1);
        query(4'd6, 1'b1);
        query(4'd8, 1'b0);
        query(4'd0, 1'b0);

        // Equality with forwarding
        query_fwd(32'd5, 32'd5, 4'd0);
        query(4'd9, 1'b1);
        query(4'd8, 1'b0);

        // Backpressure with a flag write during the hold
        ReqValid = 1'b1;
        ReqCond  = 4'd7;
        #1;
        check("bp_accept", 32'(ReqReady), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_cmp(32'd0, 32'hFFFF_FFFF);
                FlagWe = 1'b1;
            end
            #1;
            check("bp_ready", 32'(ReqReady), 32'd0);
            check("bp_valid", 32'(RspValid), 32'd1);
            check("bp_taken", 32'(RspTaken), 32'd1);
            step();
            FlagWe = 1'b0;
        end
        check("bp_flags", 32'(Flags), 32'(ref_flags(32'd0, 32'hFFFF_FFFF)));
        RspReady = 1'b1;
        #1;
        check("b2b_ready", 32'(ReqReady), 32'd1);
        step();
        bump(1'b1);
        ReqValid = 1'b0;
        check("b2b_valid", 32'(RspValid), 32'd1);
        check("b2b_taken", 32'(RspTaken), 32'd0);
        check("b2b_cnt", 32'(TakenCnt), 32'(exp_cnt));
        step();
        RspReady = 1'b0;
        check("b2b_done", 32'(RspValid), 32'd0);

        // Randomized compares and conditions
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                2: b = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: b = $urandom;
            endcase
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                query_fwd(a, b, c);
            end else begin
                write_flags(a, b);
                query(c, ref_taken(a, b, c));
            end
        end

        // Saturating counter
        for (int i = 0; i < 5; i++) query(4'd14, 1'b1);
        check("cnt_sat", 32'(TakenCnt), 32'(CNT_MAX));
        query(4'd15, 1'b0);
        query(4'd15, 1'b0);
        check("cnt_nv", 32'(TakenCnt), 32'(CNT_MAX));

        // Reset while a response is pending
        ReqValid = 1'b1;
        ReqCond  = 4'd14;
        step();
        ReqValid = 1'b0;
        check("mid_valid", 32'(RspValid), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        exp_cnt = 0;
        check("mid_rst_valid", 32'(RspValid), 32'd0);
        check("mid_rst_taken", 32'(RspTaken), 32'd0);
        check("mid_rst_cnt", 32'(TakenCnt), 32'd0);
        check("mid_rst_fvalid", 32'(FlagsValid), 32'd0);
        ReqValid = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ReqReady), 32'd0);
        ReqValid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
